uart8_tx: RTL and testbench
===========================

Name: uart8_tx

Overview:
- 8-bit UART transmitter; the transmit-side counterpart of the Uart8 receiver.
- Serialises one byte per request as start bit, 8 data bits LSB first, optional parity, then 1 or 2 stop bits, at BAUD_RATE derived from CLOCK_RATE.
- Sits beside the receiver inside the Uart8 top level and drives the board TX pin.

Parameters:
- CLOCK_RATE, 12000000, system clock frequency in Hz.
- BAUD_RATE, 9600, line rate in bit/s.
- PARITY, 0, 0 = none, 1 = odd, 2 = even.
- STOP_BITS, 1, number of stop bits, either 1 or 2.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rstN  in  1  asynchronous, active-low reset.
- txEn  in  1  transmitter enable; a start request is accepted only while this is 1.
- txStart  in  1  start request, sampled on clk.
- txIn  in  8  byte to send, captured when a request is accepted.
- txOut  out  1  serial line; idle level is 1.
- txBusy  out  1  high while a frame is in progress.
- txDone  out  1  one-cycle pulse at the end of a frame.

Behaviour:
- Reset and clock: one clock (clk). rstN is asynchronous and active-low; while it is 0, state = IDLE, txOut = 1, txBusy = 0, txDone = 0, and counters and shift register clear. Assertion mid-frame aborts the frame immediately: the line returns to 1 and no txDone is produced.
- Bit period: DIV = CLOCK_RATE / BAUD_RATE, integer truncation (1250 at the defaults). Every bit is held on txOut for exactly DIV cycles. Counter width is clog2(DIV).
- Accept: in IDLE, on an edge where txEn = 1 and txStart = 1, latch txIn. On the next cycle txOut = 0 (start bit) and txBusy = 1.
- Ignored requests: txStart while busy, or while txEn = 0, is ignored and not queued.
- States: IDLE -> START -> DATA -> PARITY -> STOP -> IDLE.
  - START: one bit period.
  - DATA: 8 bit periods, shift register right-shifts and bit index counts 0..7, LSB first.
  - PARITY: one bit period; skipped when PARITY = 0. The odd value makes the count of ones across data + parity odd; the even value makes it even.
  - STOP: STOP_BITS x DIV cycles with txOut = 1.
- txEn deasserted mid-frame: the current frame completes normally; only new acceptance is blocked.
- End of frame: on the first cycle back in IDLE, txDone = 1 for exactly one cycle and txBusy = 0.
  - A txStart present in that same cycle is accepted, giving back-to-back frames with no extra idle time.
  - That start bit begins on the following cycle.
- Frame length (txBusy high): (1 + 8 + (PARITY != 0) + STOP_BITS) x DIV cycles. For 8N1 at the defaults this is 12500 cycles.
- txIn changes after acceptance have no effect on the frame in progress.
- Elaboration checks: elaboration fails if DIV < 2, if STOP_BITS is not 1 or 2, or if PARITY > 2.

Decomposition:
- Package uart_pkg: the tx state enum (IDLE, START, DATA, PARITY, STOP) and the parity constants (PAR_NONE = 0, PAR_ODD = 1, PAR_EVEN = 2). The receiver shares it for its framing constants.
- Sub-module uart_baud_gen: DIV counter producing a one-cycle bitTick. It restarts on frame acceptance so the start bit is a full period. It is reusable by the receiver.

Test Plan:
- 8N1, txIn = 8'h55, single txStart pulse:
  - Line reads 0,1,0,1,0,1,0,1,0,1 (start, data LSB first, stop).
  - Each bit is 1250 cycles.
  - txBusy is high for 12500 cycles, followed by a single txDone pulse.
- PARITY = 2, txIn = 8'h07: parity bit = 1, frame is 11 bits. PARITY = 1, same byte: parity bit = 0.
- STOP_BITS = 2, txIn = 8'hA3: the stop level holds for 2500 cycles before txDone.
- Back-to-back: txStart held high with txIn = 8'h01 then 8'hFE: the second start bit begins 1 cycle after txDone, with no idle gap.
- Ignored requests:
  - txStart pulses mid-frame produce no change.
  - txStart with txEn = 0 leaves txOut = 1 and txBusy = 0.
  - Dropping txEn mid-frame still completes the frame and pulses txDone.
- Reset mid-frame: rstN low during bit 3 drives txOut = 1 and txBusy = 0 asynchronously, with no txDone. After release, a new frame with 8'hC3 transmits correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART framing definitions: transmitter state encoding, parity modes
// and the parity helper used by both directions of the link.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } tx_state_e;

  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  // Parity bit that makes data + parity carry an odd or even count of ones.
  function automatic logic parity_bit(input logic [7:0] data, input int mode);
    return (mode == PAR_ODD) ? ~(^data) : (^data);
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period timer: counts DIV clocks and emits a one-cycle bitTick on the last
// cycle of each period. restart realigns the period to a new frame.
module uart_baud_gen #(
  parameter int DIV = 1250
) (
  input  logic clk,
  input  logic rstN,
  input  logic restart,
  output logic bitTick
);

  localparam int CW = $clog2(DIV);

  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      cnt_q <= '0;
    end else if (restart || (cnt_q == CW'(DIV - 1))) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

  assign bitTick = (cnt_q == CW'(DIV - 1));

endmodule

// File: rtl/uart8_tx.sv
// 8-bit UART transmitter: start bit, 8 data bits LSB first, optional parity,
// then 1 or 2 stop bits, each held for CLOCK_RATE / BAUD_RATE clocks.
module uart8_tx
  import uart_pkg::*;
#(
  parameter int CLOCK_RATE = 12000000,
  parameter int BAUD_RATE  = 9600,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic       clk,
  input  logic       rstN,
  input  logic       txEn,
  input  logic       txStart,
  input  logic [7:0] txIn,
  output logic       txOut,
  output logic       txBusy,
  output logic       txDone
);

  localparam int DIV = CLOCK_RATE / BAUD_RATE;

  if (DIV < 2) begin : g_bad_div
    $error("uart8_tx: CLOCK_RATE / BAUD_RATE must be at least 2");
  end
  if ((STOP_BITS != 1) && (STOP_BITS != 2)) begin : g_bad_stop
    $error("uart8_tx: STOP_BITS must be 1 or 2");
  end
  if ((PARITY < 0) || (PARITY > 2)) begin : g_bad_parity
    $error("uart8_tx: PARITY must be 0, 1 or 2");
  end

  tx_state_e  state_q;
  logic [7:0] shift_q;
  logic [2:0] bitIdx_q;
  logic       stopCnt_q;
  logic       parBit_q;
  logic       txOut_q;
  logic       txBusy_q;
  logic       txDone_q;

  logic accept;
  logic bitTick;

  assign accept = (state_q == ST_IDLE) && txEn && txStart;

  uart_baud_gen #(
    .DIV(DIV)
  ) u_baud (
    .clk    (clk),
    .rstN   (rstN),
    .restart(accept),
    .bitTick(bitTick)
  );

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state_q   <= ST_IDLE;
      shift_q   <= '0;
      bitIdx_q  <= '0;
      stopCnt_q <= 1'b0;
      parBit_q  <= 1'b0;
      txOut_q   <= 1'b1;
      txBusy_q  <= 1'b0;
      txDone_q  <= 1'b0;
    end else begin
      txDone_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            shift_q  <= txIn;
            parBit_q <= parity_bit(txIn, PARITY);
            bitIdx_q <= '0;
            txOut_q  <= 1'b0;
            txBusy_q <= 1'b1;
            state_q  <= ST_START;
          end
        end
        ST_START: begin
          if (bitTick) begin
            txOut_q <= shift_q[0];
            state_q <= ST_DATA;
          end
        end
        ST_DATA: begin
          // shift_q[0] is on the line; shift_q[1] becomes the next bit.
          if (bitTick) begin
            shift_q  <= shift_q >> 1;
            bitIdx_q <= bitIdx_q + 3'd1;
            if (bitIdx_q == 3'd7) begin
              if (PARITY != PAR_NONE) begin
                txOut_q <= parBit_q;
                state_q <= ST_PARITY;
              end else begin
                txOut_q   <= 1'b1;
                stopCnt_q <= 1'b0;
                state_q   <= ST_STOP;
              end
            end else begin
              txOut_q <= shift_q[1];
            end
          end
        end
        ST_PARITY: begin
          if (bitTick) begin
            txOut_q   <= 1'b1;
            stopCnt_q <= 1'b0;
            state_q   <= ST_STOP;
          end
        end
        ST_STOP: begin
          if (bitTick) begin
            if (stopCnt_q == 1'(STOP_BITS - 1)) begin
              txBusy_q <= 1'b0;
              txDone_q <= 1'b1;
              state_q  <= ST_IDLE;
            end else begin
              stopCnt_q <= stopCnt_q + 1'b1;
            end
          end
        end
        default: begin
          txOut_q  <= 1'b1;
          txBusy_q <= 1'b0;
          state_q  <= ST_IDLE;
        end
      endcase
    end
  end

  assign txOut  = txOut_q;
  assign txBusy = txBusy_q;
  assign txDone = txDone_q;

endmodule

// File: tb/tb_uart8_tx.sv
// Bench for uart8_tx: four configurations share one stimulus stream and are
// compared every cycle against a frame-level reference model.
module tb_uart8_tx;

  logic       clk = 1'b0;
  logic       rstN;
  logic       txEn;
  logic       txStart;
  logic [7:0] txIn;
  logic [3:0] txOut_w;
  logic [3:0] txBusy_w;
  logic [3:0] txDone_w;

  int total = 0;
  int bad   = 0;
  bit chk_on = 1'b0;

  always #5 clk = ~clk;

  // Configurations: 8N1 default, 8E1 DIV 8, 8O1 DIV 7, 8N2 DIV 2.
  int dv[4]  = '{1250, 8, 7, 2};
  int par[4] = '{0, 2, 1, 0};
  int sb[4]  = '{1, 1, 1, 2};

  uart8_tx #(.CLOCK_RATE(12000000), .BAUD_RATE(9600), .PARITY(0), .STOP_BITS(1)) u_dut0 (
    .clk(clk), .rstN(rstN), .txEn(txEn), .txStart(txStart), .txIn(txIn),
    .txOut(txOut_w[0]), .txBusy(txBusy_w[0]), .txDone(txDone_w[0]));
  uart8_tx #(.CLOCK_RATE(80), .BAUD_RATE(10), .PARITY(2), .STOP_BITS(1)) u_dut1 (
    .clk(clk), .rstN(rstN), .txEn(txEn), .txStart(txStart), .txIn(txIn),
    .txOut(txOut_w[1]), .txBusy(txBusy_w[1]), .txDone(txDone_w[1]));
  uart8_tx #(.CLOCK_RATE(70), .BAUD_RATE(10), .PARITY(1), .STOP_BITS(1)) u_dut2 (
    .clk(clk), .rstN(rstN), .txEn(txEn), .txStart(txStart), .txIn(txIn),
    .txOut(txOut_w[2]), .txBusy(txBusy_w[2]), .txDone(txDone_w[2]));
  uart8_tx #(.CLOCK_RATE(25), .BAUD_RATE(10), .PARITY(0), .STOP_BITS(2)) u_dut3 (
    .clk(clk), .rstN(rstN), .txEn(txEn), .txStart(txStart), .txIn(txIn),
    .txOut(txOut_w[3]), .txBusy(txBusy_w[3]), .txDone(txDone_w[3]));

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference frame: list of line levels, one entry per bit period.
  function automatic logic [11:0] frame_bits(input logic [7:0] d, input int p);
    logic [11:0] f;
    int ones;
    f      = '1;
    f[0]   = 1'b0;
    f[8:1] = d;
    ones   = $countones(d);
    if (p == 1) f[9] = (ones % 2 == 0);
    if (p == 2) f[9] = (ones % 2 == 1);
    return f;
  endfunction

  function automatic int frame_len(input int p, input int s);
    return 9 + ((p != 0) ? 1 : 0) + s;
  endfunction

  int          cyc[4]  = '{-1, -1, -1, -1};
  int          nb[4]   = '{0, 0, 0, 0};
  logic [11:0] fb[4]   = '{12'hFFF, 12'hFFF, 12'hFFF, 12'hFFF};
  logic        dexp[4] = '{1'b0, 1'b0, 1'b0, 1'b0};

  always @(posedge clk or negedge rstN) begin
    for (int k = 0; k < 4; k++) begin
      if (!rstN) begin
        cyc[k]  <= -1;
        dexp[k] <= 1'b0;
      end else if (cyc[k] >= 0) begin
        if (cyc[k] + 1 == nb[k] * dv[k]) begin
          cyc[k]  <= -1;
          dexp[k] <= 1'b1;
        end else begin
          cyc[k]  <= cyc[k] + 1;
          dexp[k] <= 1'b0;
        end
      end else begin
        dexp[k] <= 1'b0;
        if (txEn && txStart) begin
          fb[k]  <= frame_bits(txIn, par[k]);
          nb[k]  <= frame_len(par[k], sb[k]);
          cyc[k] <= 0;
        end
      end
    end
  end

  function automatic logic exp_line(input int k);
    return (cyc[k] < 0) ? 1'b1 : fb[k][cyc[k] / dv[k]];
  endfunction

  always @(negedge clk) begin
    if (chk_on) begin
      for (int k = 0; k < 4; k++) begin
        check_eq($sformatf("model%0d", k), {txOut_w[k], txBusy_w[k], txDone_w[k]},
                 {exp_line(k), (cyc[k] >= 0), dexp[k]});
      end
    end
  end

  task automatic wait_done(input int k, input int bound, output int waited);
    waited = 0;
    while (!txDone_w[k] && waited < bound) begin
      @(negedge clk);
      waited++;
    end
    check_eq($sformatf("done%0d_seen", k), txDone_w[k], 1'b1);
  endtask

  // Sends a pulse and captures the 10 line levels of the 8N1 instance.
  task automatic run_8n1(input logic [7:0] d, output logic [9:0] cap, output int busyN);
    txIn    = d;
    txStart = 1'b1;
    @(negedge clk);
    txStart = 1'b0;
    txIn    = 8'($urandom);
    cap     = '0;
    busyN   = 0;
    while (txBusy_w[0] && busyN < 13000) begin
      if (busyN % 1250 == 625 && busyN < 12500) cap[busyN / 1250] = txOut_w[0];
      busyN++;
      @(negedge clk);
    end
  endtask

  initial begin
    logic [9:0] cap;
    logic [7:0] d2;
    int         busyN;
    int         w;

    rstN = 1'b0; txEn = 1'b0; txStart = 1'b0; txIn = 8'h00;
    repeat (3) @(negedge clk);
    chk_on = 1'b1;
    for (int k = 0; k < 4; k++)
      check_eq($sformatf("reset%0d", k), {txOut_w[k], txBusy_w[k], txDone_w[k]}, 3'b100);
    rstN = 1'b1;
    @(negedge clk);

    // 8N1 0x55 at the default rate.
    txEn = 1'b1;
    run_8n1(8'h55, cap, busyN);
    check_eq("a_busy_len", busyN, 12500);
    check_eq("a_bits", cap, 10'b1010101010);
    check_eq("a_done", txDone_w[0], 1'b1);
    @(negedge clk);
    check_eq("a_done_1cyc", txDone_w[0], 1'b0);

    // Parity on 0x07: even -> 1, odd -> 0.
    txIn = 8'h07; txStart = 1'b1;
    @(negedge clk);
    txStart = 1'b0;
    repeat (66) @(negedge clk);
    check_eq("odd_par", txOut_w[2], 1'b0);
    repeat (10) @(negedge clk);
    check_eq("even_par", txOut_w[1], 1'b1);
    repeat (12) @(negedge clk);
    check_eq("even_len", {txBusy_w[1], txDone_w[1]}, 2'b01);

    // Two stop bits on 0xA3; the 8N1 instance is busy and ignores this.
    txIn = 8'hA3; txStart = 1'b1;
    @(negedge clk);
    txStart = 1'b0;
    repeat (18) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      check_eq("stop2_hold", {txOut_w[3], txBusy_w[3], txDone_w[3]}, 3'b110);
      @(negedge clk);
    end
    check_eq("stop2_done", {txBusy_w[3], txDone_w[3]}, 2'b01);
    check_eq("ign_busy0", txBusy_w[0], 1'b1);

    // Back-to-back with txStart held high.
    repeat (100) @(negedge clk);
    txIn = 8'h01; txStart = 1'b1;
    @(negedge clk);
    txIn = 8'hFE;
    wait_done(1, 200, w);
    check_eq("b2b_len", w, 88);
    @(negedge clk);
    check_eq("b2b_start", {txOut_w[1], txBusy_w[1]}, 2'b01);
    d2 = '0;
    for (int c = 0; c < 72; c++) begin
      if (c % 8 == 4 && c >= 8) d2[c / 8 - 1] = txOut_w[1];
      @(negedge clk);
    end
    txStart = 1'b0;
    check_eq("b2b_byte2", d2, 8'hFE);

    // Requests while disabled are dropped; disabling mid-frame completes it.
    repeat (200) @(negedge clk);
    txEn = 1'b0; txStart = 1'b1;
    repeat (5) begin
      @(negedge clk);
      check_eq("en0_idle", {txOut_w[1], txBusy_w[1]}, 2'b10);
    end
    txEn = 1'b1;
    @(negedge clk);
    txStart = 1'b0; txEn = 1'b0;
    wait_done(1, 200, w);
    check_eq("en_drop_len", w, 88);
    txEn = 1'b1;

    // Randomised traffic with occasional asynchronous resets.
    for (int i = 0; i < 10000; i++) begin
      @(negedge clk);
      if ($urandom_range(0, 1999) == 0) begin
        #3 rstN = 1'b0;
        #1;
        for (int k = 0; k < 4; k++)
          check_eq($sformatf("rnd_rst%0d", k), {txOut_w[k], txBusy_w[k], txDone_w[k]}, 3'b100);
        @(negedge clk);
        rstN = 1'b1;
      end
      txEn    = ($urandom_range(0, 7) != 0);
      txStart = ($urandom_range(0, 3) == 0);
      txIn    = 8'($urandom);
    end

    // Reset during data bit 2 (line bit 3) of a 0xC3 frame, then resend.
    txStart = 1'b0; txEn = 1'b1;
    @(negedge clk);
    #3 rstN = 1'b0;
    @(negedge clk);
    rstN = 1'b1;
    @(negedge clk);
    txIn = 8'hC3; txStart = 1'b1;
    @(negedge clk);
    txStart = 1'b0;
    repeat (3 * 1250 + 600) @(negedge clk);
    check_eq("mid_busy", txBusy_w[0], 1'b1);
    #3 rstN = 1'b0;
    #1;
    check_eq("mid_rst_async", {txOut_w[0], txBusy_w[0], txDone_w[0]}, 3'b100);
    @(negedge clk);
    rstN = 1'b1;
    @(negedge clk);
    check_eq("mid_rst_nodone", {txOut_w[0], txBusy_w[0], txDone_w[0]}, 3'b100);
    run_8n1(8'hC3, cap, busyN);
    check_eq("c3_busy_len", busyN, 12500);
    check_eq("c3_bits", cap, 10'b1110000110);
    check_eq("c3_done", txDone_w[0], 1'b1);

    repeat (5) @(negedge clk);
    chk_on = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
